vend_dispenser: RTL and testbench

VEND_DISPENSER -- requirements
Module: vend_dispenser

---
 rtl/vend_dispenser.sv | 148 ++++++++++++++
 tb/tb_vend_dispenser.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_dispenser.sv
// Vend dispenser: queues dispense/change events and runs four-phase item and coin handshakes.
// Optional per-handshake statistics outputs are enabled by defining VEND_DISPENSER_STATS_EN.
module vend_dispenser #(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        out,
    input  logic [1:0]  change,
    output logic        item_req,
    input  logic        item_ack,
    output logic        coin_req,
    input  logic        coin_ack,
    input  logic        clr_fault,
    output logic        busy,
    output logic        fault,
    output logic        overflow,
    output logic        bad_code
`ifdef VEND_DISPENSER_STATS_EN
    ,
    output logic [15:0] items_cnt,
    output logic [15:0] coins_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WW-1:0] TO_LAST = WW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, ITEM_HI, ITEM_LO, COIN_HI, COIN_LO, FAULT
    } state_t;

    state_t          r_state, w_next;
    logic [2:0]      r_mem [DEPTH];
    logic [AW:0]     r_wr_ptr, r_rd_ptr;
    logic [1:0]      r_coins;
    logic [WW-1:0]   r_wait;
    logic            r_item_req, r_coin_req, r_overflow, r_bad_code;

    logic            w_ev, w_empty, w_full, w_pop, w_push, w_tmo, w_hs;
    logic [1:0]      w_coins_in;
    logic [2:0]      w_head;

    assign w_ev       = out | (change == 2'b01) | (change == 2'b10);
    assign w_coins_in = (change == 2'b01) ? 2'd1 : (change == 2'b10) ? 2'd2 : 2'd0;
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop      = (r_state == LOAD);
    // A full FIFO can still take an event on the edge that frees a slot.
    assign w_push     = w_ev && (!w_full || w_pop);
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
    assign w_tmo      = (r_wait == TO_LAST);
    assign w_hs       = (r_state == ITEM_HI) || (r_state == ITEM_LO) ||
                        (r_state == COIN_HI) || (r_state == COIN_LO);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!w_empty) w_next = LOAD;
            LOAD: begin
                if (w_head[2])              w_next = ITEM_HI;
                else if (w_head[1:0] != '0) w_next = COIN_HI;
                else                        w_next = IDLE;
            end
            ITEM_HI: begin
                if (item_ack)   w_next = ITEM_LO;
                else if (w_tmo) w_next = FAULT;
            end
            ITEM_LO: begin
                if (!item_ack)  w_next = (r_coins != '0) ? COIN_HI : IDLE;
                else if (w_tmo) w_next = FAULT;
            end
            COIN_HI: begin
                if (coin_ack)   w_next = COIN_LO;
                else if (w_tmo) w_next = FAULT;
            end
            COIN_LO: begin
                if (!coin_ack)  w_next = (r_coins > 2'd1) ? COIN_HI : IDLE;
                else if (w_tmo) w_next = FAULT;
            end
            FAULT:   if (clr_fault) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_coins    <= '0;
            r_wait     <= '0;
            r_item_req <= 1'b0;
            r_coin_req <= 1'b0;
            r_overflow <= 1'b0;
            r_bad_code <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_item_req <= (w_next == ITEM_HI);
            r_coin_req <= (w_next == COIN_HI);
            if (w_next != r_state) r_wait <= '0;
            else if (w_hs)         r_wait <= r_wait + 1'b1;
            else                   r_wait <= '0;
            if (w_push)              r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)               r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_ev && !w_push)     r_overflow <= 1'b1;
            if (change == 2'b11)     r_bad_code <= 1'b1;
            if (w_pop)
                r_coins <= w_head[1:0];
            else if (r_state == COIN_LO && !coin_ack)
                r_coins <= r_coins - 2'd1;
            else if (w_next == FAULT)
                r_coins <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {out, w_coins_in};
    end

`ifdef VEND_DISPENSER_STATS_EN
    logic [15:0] r_items_cnt, r_coins_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_items_cnt <= '0;
            r_coins_cnt <= '0;
        end else begin
            if (r_state == ITEM_LO && !item_ack) r_items_cnt <= r_items_cnt + 16'd1;
            if (r_state == COIN_LO && !coin_ack) r_coins_cnt <= r_coins_cnt + 16'd1;
        end
    end

    assign items_cnt = r_items_cnt;
    assign coins_cnt = r_coins_cnt;
`endif

    assign item_req = r_item_req;
    assign coin_req = r_coin_req;
    assign busy     = !w_empty || (r_state != IDLE);
    assign fault    = (r_state == FAULT);
    assign overflow = r_overflow;
    assign bad_code = r_bad_code;

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed bench for vend_dispenser; an optional ack responder echoes reqs two cycles late.
module tb_vend_dispenser;

    logic       clk = 1'b0;
    logic       rst, out, clr_fault;
    logic [1:0] change;
    logic       item_req, coin_req, busy, fault, overflow, bad_code;
    logic       item_ack, coin_ack;
    logic       m_item, m_coin, a_item, a_coin;
    bit         auto_ack;
`ifdef VEND_DISPENSER_STATS_EN
    logic [15:0] items_cnt, coins_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [1:0] p_item = '0, p_coin = '0;
    logic       prev_item = 1'b0, prev_coin = 1'b0;
    int         n_item = 0, n_coin = 0;
    time        t_item = 0, t_coin = 0;
    bit         both_hi = 1'b0;

    assign item_ack = auto_ack ? a_item : m_item;
    assign coin_ack = auto_ack ? a_coin : m_coin;

    vend_dispenser #(.DEPTH(4), .ACK_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .out(out), .change(change),
        .item_req(item_req), .item_ack(item_ack),
        .coin_req(coin_req), .coin_ack(coin_ack),
        .clr_fault(clr_fault), .busy(busy), .fault(fault),
        .overflow(overflow), .bad_code(bad_code)
`ifdef VEND_DISPENSER_STATS_EN
        , .items_cnt(items_cnt), .coins_cnt(coins_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (item_req && coin_req) both_hi = 1'b1;
        if (item_req && !prev_item) begin n_item++; t_item = $time; end
        if (coin_req && !prev_coin) begin n_coin++; t_coin = $time; end
        prev_item = item_req;
        prev_coin = coin_req;
        a_item = p_item[1];
        a_coin = p_coin[1];
        p_item = {p_item[0], item_req};
        p_coin = {p_coin[0], coin_req};
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input logic o, input logic [1:0] c);
        @(negedge clk);
        out = o; change = c;
        @(negedge clk);
        out = 1'b0; change = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; auto_ack = 1'b0; m_item = 1'b0; m_coin = 1'b0;
        out = 1'b0; change = 2'b00; clr_fault = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int maxc, input string name);
        for (int i = 0; i < maxc; i++) begin
            if (!busy) break;
            tick();
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, maxc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; out = 1'b0; change = 2'b00; clr_fault = 1'b0;
        m_item = 1'b0; m_coin = 1'b0; auto_ack = 1'b0;
        tick(); tick();
        checks++;
        if ({item_req, coin_req, busy, fault, overflow, bad_code} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b required 000000",
                     {item_req, coin_req, busy, fault, overflow, bad_code});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({item_req, coin_req, busy, fault} !== 4'b0) begin
            errors++;
            $display("FAIL reset_release: got %b required 0000", {item_req, coin_req, busy, fault});
        end
    endtask

    task automatic test_latency();
        pulse(1'b1, 2'b00);
        checks++;
        if (item_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL lat_capture: item_req=%b busy=%b required 0/1", item_req, busy);
        end
        tick();
        checks++;
        if (item_req !== 1'b0) begin
            errors++;
            $display("FAIL lat_load: item_req=%b required 0", item_req);
        end
        tick();
        checks++;
        if (item_req !== 1'b1 || coin_req !== 1'b0) begin
            errors++;
            $display("FAIL lat_req: item_req=%b coin_req=%b required 1/0", item_req, coin_req);
        end
        m_item = 1'b1;
        tick();
        checks++;
        if (item_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL item_lo: item_req=%b busy=%b required 0/1", item_req, busy);
        end
        m_item = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || coin_req !== 1'b0) begin
            errors++;
            $display("FAIL lat_done: busy=%b coin_req=%b required 0/0", busy, coin_req);
        end
    endtask

    task automatic test_item_coin();
        int bi, bc;
`ifdef VEND_DISPENSER_STATS_EN
        logic [15:0] si, sc;
        si = items_cnt; sc = coins_cnt;
`endif
        bi = n_item; bc = n_coin;
        auto_ack = 1'b1;
        pulse(1'b1, 2'b01);
        wait_idle(200, "item_coin_idle");
        checks++;
        if (n_item - bi != 1 || n_coin - bc != 1) begin
            errors++;
            $display("FAIL item_coin_count: items=%0d coins=%0d required 1/1", n_item - bi, n_coin - bc);
        end
        checks++;
        if (t_item >= t_coin) begin
            errors++;
            $display("FAIL item_first: item rise %0t coin rise %0t, required item earlier", t_item, t_coin);
        end
        checks++;
        if (coin_ack !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_ack: coin_ack=%b when busy fell, required 0", coin_ack);
        end
`ifdef VEND_DISPENSER_STATS_EN
        checks++;
        if (items_cnt != si + 16'd1 || coins_cnt != sc + 16'd1) begin
            errors++;
            $display("FAIL stats_inc: items=%0d coins=%0d required %0d/%0d",
                     items_cnt, coins_cnt, si + 16'd1, sc + 16'd1);
        end
`endif
    endtask

    task automatic test_rs10();
        int bi, bc;
        bi = n_item; bc = n_coin;
        auto_ack = 1'b1;
        pulse(1'b0, 2'b10);
        wait_idle(200, "rs10_idle");
        checks++;
        if (n_item - bi != 0 || n_coin - bc != 2) begin
            errors++;
            $display("FAIL rs10_count: items=%0d coins=%0d required 0/2", n_item - bi, n_coin - bc);
        end
    endtask

    task automatic test_bad_code();
        int bi, bc;
        do_reset();
        pulse(1'b0, 2'b11);
        checks++;
        if (bad_code !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_code_set: bad_code=%b busy=%b required 1/0", bad_code, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || item_req !== 1'b0) begin
            errors++;
            $display("FAIL bad_code_nopush: busy=%b item_req=%b required 0/0", busy, item_req);
        end
        bi = n_item; bc = n_coin;
        auto_ack = 1'b1;
        pulse(1'b1, 2'b11);
        wait_idle(200, "bad_item_idle");
        checks++;
        if (n_item - bi != 1 || n_coin - bc != 0 || bad_code !== 1'b1) begin
            errors++;
            $display("FAIL bad_item: items=%0d coins=%0d bad_code=%b required 1/0/1",
                     n_item - bi, n_coin - bc, bad_code);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        @(negedge clk);
        out = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        out = 1'b0;
        checks++;
        if (overflow !== 1'b0 || item_req !== 1'b1) begin
            errors++;
            $display("FAIL five_events: overflow=%b item_req=%b required 0/1", overflow, item_req);
        end
        out = 1'b1;
        tick();
        out = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL sixth_event: overflow=%b required 1", overflow);
        end
    endtask

    task automatic test_timeout_pop();
        int bi;
        do_reset();
        @(negedge clk);
        out = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        out = 1'b0;
        for (int i = 0; i < 252; i++) tick();
        checks++;
        if (fault !== 1'b0 || item_req !== 1'b1) begin
            errors++;
            $display("FAIL pre_timeout: fault=%b item_req=%b required 0/1", fault, item_req);
        end
        tick();
        checks++;
        if (fault !== 1'b1 || item_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout: fault=%b item_req=%b busy=%b required 1/0/1", fault, item_req, busy);
        end
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL clr_fault: fault=%b required 0", fault);
        end
        tick();
        out = 1'b1;
        bi = n_item;
        p_item = '0; p_coin = '0; a_item = 1'b0; a_coin = 1'b0;
        auto_ack = 1'b1;
        tick();
        out = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL push_on_pop: overflow=%b required 0", overflow);
        end
        wait_idle(400, "drain_idle");
        checks++;
        if (n_item - bi != 5) begin
            errors++;
            $display("FAIL drain_count: items=%0d required 5", n_item - bi);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        pulse(1'b0, 2'b11);
        p_item = '0; p_coin = '0; a_item = 1'b0; a_coin = 1'b0;
        auto_ack = 1'b1;
        pulse(1'b0, 2'b01);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (coin_req) begin seen = 1'b1; break; end
            tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_coin_req: coin_req=%b required 1", coin_req);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({coin_req, item_req, busy, fault, overflow, bad_code} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: got %b required 000000",
                     {coin_req, item_req, busy, fault, overflow, bad_code});
        end
`ifdef VEND_DISPENSER_STATS_EN
        checks++;
        if (items_cnt !== 16'd0 || coins_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stats_reset: items=%0d coins=%0d required 0/0", items_cnt, coins_cnt);
        end
`endif
        auto_ack = 1'b0;
        tick();
        rst = 1'b0;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || coin_req !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: busy=%b coin_req=%b required 0/0", busy, coin_req);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_item_coin();
        test_rs10();
        test_bad_code();
        test_overflow();
        test_timeout_pop();
        test_reset_mid();
        checks++;
        if (both_hi) begin
            errors++;
            $display("FAIL req_exclusive: item_req and coin_req seen high together, required never");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
